id_ex_operand_stage: RTL
========================

Name: id_ex_operand_stage

Overview:
- ID/EX pipeline register and EX-stage operand front end that directly feeds the ALU.
- Latches decoded instruction fields and control bits from ID each cycle.
- Applies EX/MEM and MEM/WB forwarding to the latched register operands and selects the immediate.
- Decodes alu_op/funct into the 4-bit ALU operation code; drives alu_in1, alu_in2 and alu_operation, plus the control bits that travel to EX/MEM.

Parameters:
- DATA_W, 32, datapath width
- REG_AW, 5, register-address width

Ports:
- clk  input  1  single clock; all state updates on posedge
- rst  input  1  synchronous, active-high reset
- stall  input  1  hold the current contents
- flush  input  1  load a bubble
- id_valid  input  1  ID holds a real instruction
- id_rs_data, id_rt_data  input  DATA_W  register-file read data
- id_imm  input  DATA_W  sign-extended immediate
- id_rs, id_rt, id_rd  input  REG_AW  register addresses
- id_funct  input  6  R-type funct field
- id_alu_op  input  2  main-decoder ALU class
- id_alu_src, id_reg_dst, id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg  input  1 each  control bits
- exm_reg_write  input  1  EX/MEM writes a register
- exm_rd  input  REG_AW  EX/MEM destination
- exm_result  input  DATA_W  EX/MEM ALU result
- wb_reg_write  input  1  MEM/WB writes a register
- wb_rd  input  REG_AW  MEM/WB destination
- wb_result  input  DATA_W  MEM/WB writeback value
- alu_in1, alu_in2  output  DATA_W  ALU operands
- alu_operation  output  4  ALU operation code
- ex_store_data  output  DATA_W  forwarded rt value, used by stores
- ex_write_reg  output  REG_AW  rd if reg_dst=1, else rt
- ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg  output  1 each  registered control
- ex_illegal  output  1  valid R-type with unsupported funct

Behaviour:
- Register update on posedge clk. Priority: rst > flush > stall > load.
- rst or flush: all stage registers cleared to 0, producing a bubble.
  - Resulting outputs: ex_valid=0, all ex_* controls=0, ex_write_reg=0, ex_illegal=0, alu_operation=0010.
  - alu_in1 and alu_in2 equal the forwarded-or-zero values described below; with rs=rt=0 they are 0.
- stall with no flush: every register holds its value; outputs stay stable except through changing forwarding inputs.
- load: every field captured from id_*. If id_valid=0, all control bits are captured as 0 (bubble), whatever the id_* control inputs are.
- Latency: one cycle from the ID inputs to the outputs.
- Forwarding is combinational on the registered rs/rt and live forwarding inputs. For each operand (rs -> fwdA, rt -> fwdB):
  - Use exm_result if exm_reg_write and exm_rd == reg and reg != 0.
  - Otherwise use wb_result if wb_reg_write and wb_rd == reg and reg != 0.
  - Otherwise use the registered register-file data.
  - EX/MEM always wins over MEM/WB. Register 0 is never forwarded.
- Operand outputs:
  - alu_in1 = fwdA.
  - alu_in2 = imm if alu_src else fwdB.
  - ex_store_data = fwdB, regardless of alu_src.
- alu_operation, combinational from registered alu_op/funct:
  - alu_op 00: 0010 (add, loads/stores)
  - alu_op 01: 0110 (sub, branches)
  - alu_op 11: 0001 (or, ori)
  - alu_op 10: decoded from funct:
    - 100000 -> 0010
    - 100010 -> 0110
    - 100100 -> 0000
    - 100101 -> 0001
    - 101010 -> 0111
    - 100111 -> 1100
    - any other funct -> 0010, with ex_illegal=1 when ex_valid=1
- ex_illegal is 0 whenever alu_op != 10 or ex_valid = 0.
- No combinational path from id_* to any output.

Test Plan:
- Reset then idle: hold rst=1 for 2 cycles, id_* random -> all ex_* = 0, alu_operation=0010, alu_in1=alu_in2=0.
- Plain R-type:
  - Stimulus: load rs=1 (data 7), rt=2 (data 5), alu_op=10, funct=100010, reg_dst=1, rd=3, no forwarding.
  - Required: the next cycle gives alu_in1=7, alu_in2=5, alu_operation=0110, ex_write_reg=3, ex_reg_write as loaded.
- Forwarding priority:
  - Stimulus: registered rs=4, with exm_reg_write=1, exm_rd=4, exm_result=0xAA and wb_reg_write=1, wb_rd=4, wb_result=0xBB.
  - Required: alu_in1=0xAA. Dropping exm_reg_write gives 0xBB. Setting rs=0 with both forwarding sources at rd=0 gives the register-file data.
- Immediate plus store:
  - Stimulus: alu_src=1, imm=0xFFFFFFFC, rt=5 forwarded from wb with 0x1234, alu_op=00.
  - Required: alu_in2=0xFFFFFFFC, ex_store_data=0x1234, alu_operation=0010.
- Stall/flush:
  - Stall for 3 cycles while id_* change -> outputs unchanged.
  - Assert flush together with stall -> bubble the next cycle: ex_valid=0, ex_mem_write=0.
- Illegal funct:
  - alu_op=10, funct=000000, id_valid=1 -> alu_operation=0010, ex_illegal=1.
  - Same with id_valid=0 -> ex_illegal=0.

Source files
------------

// File: rtl/id_ex_operand_stage.sv
// rtl/id_ex_operand_stage.sv - ID/EX pipeline register with EX operand forwarding and ALU control decode
//
// Purpose:
//   Captures the decoded instruction from ID once per cycle, then forms the ALU
//   operands through EX/MEM and MEM/WB forwarding. It also selects the immediate
//   and decodes alu_op/funct into the 4-bit ALU operation.
//
// Ports:
//   clk, rst            clock and synchronous active-high reset
//   stall, flush        hold the stage / load a bubble (flush wins over stall)
//   id_*                decoded fields and control bits from ID
//   exm_*, wb_*         live forwarding sources from EX/MEM and MEM/WB
//   alu_in1, alu_in2    forwarded ALU operands (alu_in2 may be the immediate)
//   alu_operation       4-bit ALU operation code
//   ex_store_data       forwarded rt value for stores
//   ex_write_reg        destination register (rd or rt)
//   ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg
//                       registered control travelling to EX/MEM
//   ex_illegal          valid R-type instruction with an unsupported funct

module id_ex_operand_stage #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              flush,
    input  logic              id_valid,
    input  logic [DATA_W-1:0] id_rs_data,
    input  logic [DATA_W-1:0] id_rt_data,
    input  logic [DATA_W-1:0] id_imm,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic [REG_AW-1:0] id_rd,
    input  logic [5:0]        id_funct,
    input  logic [1:0]        id_alu_op,
    input  logic              id_alu_src,
    input  logic              id_reg_dst,
    input  logic              id_reg_write,
    input  logic              id_mem_read,
    input  logic              id_mem_write,
    input  logic              id_mem_to_reg,
    input  logic              exm_reg_write,
    input  logic [REG_AW-1:0] exm_rd,
    input  logic [DATA_W-1:0] exm_result,
    input  logic              wb_reg_write,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic [DATA_W-1:0] wb_result,
    output logic [DATA_W-1:0] alu_in1,
    output logic [DATA_W-1:0] alu_in2,
    output logic [3:0]        alu_operation,
    output logic [DATA_W-1:0] ex_store_data,
    output logic [REG_AW-1:0] ex_write_reg,
    output logic              ex_valid,
    output logic              ex_reg_write,
    output logic              ex_mem_read,
    output logic              ex_mem_write,
    output logic              ex_mem_to_reg,
    output logic              ex_illegal
);

    // Stage registers
    logic              valid_q,      valid_d;
    logic [DATA_W-1:0] rs_data_q,    rs_data_d;
    logic [DATA_W-1:0] rt_data_q,    rt_data_d;
    logic [DATA_W-1:0] imm_q,        imm_d;
    logic [REG_AW-1:0] rs_q,         rs_d;
    logic [REG_AW-1:0] rt_q,         rt_d;
    logic [REG_AW-1:0] rd_q,         rd_d;
    logic [5:0]        funct_q,      funct_d;
    logic [1:0]        alu_op_q,     alu_op_d;
    logic              alu_src_q,    alu_src_d;
    logic              reg_dst_q,    reg_dst_d;
    logic              reg_write_q,  reg_write_d;
    logic              mem_read_q,   mem_read_d;
    logic              mem_write_q,  mem_write_d;
    logic              mem_to_reg_q, mem_to_reg_d;

    // Next-state: stall holds everything, otherwise load from ID.
    // An invalid ID slot loads its control bits as zero, so it behaves as a bubble.
    always_comb begin
        valid_d      = valid_q;
        rs_data_d    = rs_data_q;
        rt_data_d    = rt_data_q;
        imm_d        = imm_q;
        rs_d         = rs_q;
        rt_d         = rt_q;
        rd_d         = rd_q;
        funct_d      = funct_q;
        alu_op_d     = alu_op_q;
        alu_src_d    = alu_src_q;
        reg_dst_d    = reg_dst_q;
        reg_write_d  = reg_write_q;
        mem_read_d   = mem_read_q;
        mem_write_d  = mem_write_q;
        mem_to_reg_d = mem_to_reg_q;
        if (!stall) begin
            valid_d      = id_valid;
            rs_data_d    = id_rs_data;
            rt_data_d    = id_rt_data;
            imm_d        = id_imm;
            rs_d         = id_rs;
            rt_d         = id_rt;
            rd_d         = id_rd;
            funct_d      = id_funct;
            alu_op_d     = id_valid ? id_alu_op : 2'b00;
            alu_src_d    = id_valid & id_alu_src;
            reg_dst_d    = id_valid & id_reg_dst;
            reg_write_d  = id_valid & id_reg_write;
            mem_read_d   = id_valid & id_mem_read;
            mem_write_d  = id_valid & id_mem_write;
            mem_to_reg_d = id_valid & id_mem_to_reg;
        end
    end

    // rst and flush both clear the whole stage; flush overrides stall.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            valid_q      <= 1'b0;
            rs_data_q    <= '0;
            rt_data_q    <= '0;
            imm_q        <= '0;
            rs_q         <= '0;
            rt_q         <= '0;
            rd_q         <= '0;
            funct_q      <= '0;
            alu_op_q     <= '0;
            alu_src_q    <= 1'b0;
            reg_dst_q    <= 1'b0;
            reg_write_q  <= 1'b0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            mem_to_reg_q <= 1'b0;
        end else begin
            valid_q      <= valid_d;
            rs_data_q    <= rs_data_d;
            rt_data_q    <= rt_data_d;
            imm_q        <= imm_d;
            rs_q         <= rs_d;
            rt_q         <= rt_d;
            rd_q         <= rd_d;
            funct_q      <= funct_d;
            alu_op_q     <= alu_op_d;
            alu_src_q    <= alu_src_d;
            reg_dst_q    <= reg_dst_d;
            reg_write_q  <= reg_write_d;
            mem_read_q   <= mem_read_d;
            mem_write_q  <= mem_write_d;
            mem_to_reg_q <= mem_to_reg_d;
        end
    end

    // Forwarding: the younger EX/MEM result wins over MEM/WB; r0 is hardwired zero
    // and must never pick up a forwarded value.
    logic [DATA_W-1:0] fwd_a;
    logic [DATA_W-1:0] fwd_b;

    always_comb begin
        fwd_a = rs_data_q;
        if (exm_reg_write && (exm_rd == rs_q) && (rs_q != '0)) begin
            fwd_a = exm_result;
        end else if (wb_reg_write && (wb_rd == rs_q) && (rs_q != '0)) begin
            fwd_a = wb_result;
        end
    end

    always_comb begin
        fwd_b = rt_data_q;
        if (exm_reg_write && (exm_rd == rt_q) && (rt_q != '0)) begin
            fwd_b = exm_result;
        end else if (wb_reg_write && (wb_rd == rt_q) && (rt_q != '0)) begin
            fwd_b = wb_result;
        end
    end

    // ALU control decode; unknown R-type funct falls back to add and flags illegal.
    logic [3:0] op_dec;
    logic       funct_bad;

    always_comb begin
        op_dec    = 4'b0010;
        funct_bad = 1'b0;
        case (alu_op_q)
            2'b00: op_dec = 4'b0010;
            2'b01: op_dec = 4'b0110;
            2'b11: op_dec = 4'b0001;
            default: begin
                case (funct_q)
                    6'b100000: op_dec = 4'b0010;
                    6'b100010: op_dec = 4'b0110;
                    6'b100100: op_dec = 4'b0000;
                    6'b100101: op_dec = 4'b0001;
                    6'b101010: op_dec = 4'b0111;
                    6'b100111: op_dec = 4'b1100;
                    default: begin
                        op_dec    = 4'b0010;
                        funct_bad = 1'b1;
                    end
                endcase
            end
        endcase
    end

    assign alu_in1       = fwd_a;
    assign alu_in2       = alu_src_q ? imm_q : fwd_b;
    assign ex_store_data = fwd_b;
    assign alu_operation = op_dec;
    assign ex_write_reg  = reg_dst_q ? rd_q : rt_q;
    assign ex_valid      = valid_q;
    assign ex_reg_write  = reg_write_q;
    assign ex_mem_read   = mem_read_q;
    assign ex_mem_write  = mem_write_q;
    assign ex_mem_to_reg = mem_to_reg_q;
    assign ex_illegal    = valid_q & funct_bad;

endmodule
